// File: rtl/fml_pkg.sv
// Shared constants and master-index encoding for the FML arbiter slice.
package fml_pkg;

  localparam int FML_DW    = 64;
  localparam int FML_SELW  = 8;
  localparam int FML_BURST = 4;

  // Master index encoding (one bit selects between the two masters).
  localparam logic [0:0] MST_0 = 1'b0;
  localparam logic [0:0] MST_1 = 1'b1;

endpackage

// File: rtl/fml_rr_sel.sv
// Two-input round-robin grant selection for the FML arbiter.
// When update is low, or nobody is requesting, the current grant is held.
module fml_rr_sel
  import fml_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       cur,
  input  logic       update,
  output logic       grant_next
);

  // Next owner: a lone requester wins; on a tie, the master that was not acked last wins.
  always_comb begin
    grant_next = cur;
    if (update) begin
      case (req)
        2'b01:   grant_next = MST_0;
        2'b10:   grant_next = MST_1;
        2'b11:   grant_next = (last == MST_0) ? MST_1 : MST_0;
        default: grant_next = cur;
      endcase
    end else begin
      grant_next = cur;
    end
  end

endmodule

// File: rtl/fml_arb2.sv
// Two-master round-robin arbiter for the FML memory bus.
// Address/control is muxed combinationally from the granted master. Write data
// follows a separate owner/counter so a new address phase can overlap the
// previous burst's data phase. Read data is broadcast to both masters.
module fml_arb2
  import fml_pkg::*;
#(
  parameter int fml_depth = 26,
  parameter int burst_len = FML_BURST
)(
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] m0_adr,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_ack,
  input  logic [FML_SELW-1:0]  m0_sel,
  input  logic [FML_DW-1:0]    m0_di,
  output logic [FML_DW-1:0]    m0_do,

  input  logic [fml_depth-1:0] m1_adr,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_ack,
  input  logic [FML_SELW-1:0]  m1_sel,
  input  logic [FML_DW-1:0]    m1_di,
  output logic [FML_DW-1:0]    m1_do,

  output logic [fml_depth-1:0] s_adr,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_ack,
  output logic [FML_SELW-1:0]  s_sel,
  output logic [FML_DW-1:0]    s_di,
  input  logic [FML_DW-1:0]    s_do
);

  localparam int WCW = $clog2(burst_len + 1);

  logic           grant_q,  grant_d;
  logic           last_q,   last_d;
  logic           wowner_q, wowner_d;
  logic [WCW-1:0] wcnt_q,   wcnt_d;

  logic           cur_stb;
  logic           rearb;
  logic           last_eff;

  // Re-arbitrate on an ack or when the owner lets go; an ack this cycle counts as the latest "last".
  always_comb begin
    cur_stb  = (grant_q == MST_1) ? m1_stb : m0_stb;
    rearb    = s_ack | ~cur_stb;
    last_eff = s_ack ? grant_q : last_q;
    last_d   = last_eff;
  end

  fml_rr_sel u_rr_sel (
    .req        ({m1_stb, m0_stb}),
    .last       (last_eff),
    .cur        (grant_q),
    .update     (rearb),
    .grant_next (grant_d)
  );

  // Write-data phase: an acked write reloads the beat counter and latches its owner.
  always_comb begin
    wowner_d = wowner_q;
    wcnt_d   = wcnt_q;
    if (s_ack && s_we) begin
      wowner_d = grant_q;
      wcnt_d   = WCW'(burst_len);
    end else if (wcnt_q != {WCW{1'b0}}) begin
      wcnt_d   = wcnt_q - {{(WCW-1){1'b0}}, 1'b1};
    end else begin
      wcnt_d   = {WCW{1'b0}};
    end
  end

  // State registers with synchronous reset; m0 wins the first tie because last starts at 1.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_q  <= MST_0;
      last_q   <= MST_1;
      wowner_q <= MST_0;
      wcnt_q   <= {WCW{1'b0}};
    end else begin
      grant_q  <= grant_d;
      last_q   <= last_d;
      wowner_q <= wowner_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Slave-side muxes, ack routing and read-data broadcast.
  always_comb begin
    if (grant_q == MST_1) begin
      s_adr  = m1_adr;
      s_stb  = m1_stb;
      s_we   = m1_we;
      m0_ack = 1'b0;
      m1_ack = s_ack;
    end else begin
      s_adr  = m0_adr;
      s_stb  = m0_stb;
      s_we   = m0_we;
      m0_ack = s_ack;
      m1_ack = 1'b0;
    end

    if (wcnt_q == {WCW{1'b0}}) begin
      s_sel = {FML_SELW{1'b0}};
      s_di  = {FML_DW{1'b0}};
    end else if (wowner_q == MST_1) begin
      s_sel = m1_sel;
      s_di  = m1_di;
    end else begin
      s_sel = m0_sel;
      s_di  = m0_di;
    end

    m0_do = s_do;
    m1_do = s_do;
  end

endmodule

// File: tb/tb_fml_arb2.sv
// Directed self-checking bench for fml_arb2.
module tb_fml_arb2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [25:0] m0_adr, m1_adr, s_adr;
  logic        m0_stb, m0_we, m0_ack, m1_stb, m1_we, m1_ack;
  logic [7:0]  m0_sel, m1_sel, s_sel;
  logic [63:0] m0_di, m0_do, m1_di, m1_do, s_di, s_do;
  logic        s_stb, s_we, s_ack;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [25:0] A0   = 26'h0000100;
  localparam logic [25:0] A1   = 26'h0000300;
  localparam logic [7:0]  SEL0 = 8'hA5;
  localparam logic [7:0]  SEL1 = 8'h3C;
  localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1   = 64'hFEDC_BA98_7654_3210;

  fml_arb2 #(.fml_depth(26), .burst_len(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_ack(m0_ack),
    .m0_sel(m0_sel), .m0_di(m0_di), .m0_do(m0_do),
    .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_ack(m1_ack),
    .m1_sel(m1_sel), .m1_di(m1_di), .m1_do(m1_do),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
    .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    m0_adr = A0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = SEL0; m0_di = D0;
    m1_adr = A1; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = SEL1; m1_di = D1;
    s_ack = 1'b0; s_do = 64'h0;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b%b want 00", m0_ack, m1_ack); end
    n_cmp++; if (s_sel !== 8'h00 || s_di !== 64'h0) begin n_bad++; $display("FAIL reset_wdata: got sel=%h di=%h want 0", s_sel, s_di); end
    n_cmp++; if (s_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb_idle: got %b want 0", s_stb); end
    m0_stb = 1'b1;
    #1;
    n_cmp++; if (s_stb !== 1'b1 || s_adr !== A0) begin n_bad++; $display("FAIL reset_stb_m0: got stb=%b adr=%h want 1/%h", s_stb, s_adr, A0); end
    m0_stb = 1'b0;
    step();
  endtask

  task automatic test_m0_write();
    do_reset();
    m0_stb = 1'b1; m0_we = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      s_ack = (c == 3);
      #1;
      n_cmp++; if (s_stb !== 1'b1 || s_we !== 1'b1 || s_adr !== A0) begin n_bad++; $display("FAIL wr_addr c%0d: got stb=%b we=%b adr=%h", c, s_stb, s_we, s_adr); end
      n_cmp++; if (m0_ack !== (c == 3) || m1_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack c%0d: got m0=%b m1=%b want %b/0", c, m0_ack, m1_ack, (c == 3)); end
      step();
    end
    s_ack = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      #1;
      if (c <= 7) begin
        n_cmp++; if (s_sel !== SEL0 || s_di !== D0) begin n_bad++; $display("FAIL wr_beat c%0d: got sel=%h di=%h want %h/%h", c, s_sel, s_di, SEL0, D0); end
      end else begin
        n_cmp++; if (s_sel !== 8'h00 || s_di !== 64'h0) begin n_bad++; $display("FAIL wr_end c%0d: got sel=%h di=%h want 0", c, s_sel, s_di); end
      end
      n_cmp++; if (m1_ack !== 1'b0) begin n_bad++; $display("FAIL wr_m1ack c%0d: got %b want 0", c, m1_ack); end
      step();
    end
  endtask

  task automatic test_alternate();
    logic exp_own;
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1;
    exp_own = 1'b0;
    for (int t = 0; t < 4; t++) begin
      for (int c = 1; c <= 5; c++) begin
        s_ack = (c == 5);
        #1;
        n_cmp++; if (s_adr !== (exp_own ? A1 : A0)) begin n_bad++; $display("FAIL alt_adr t%0d c%0d: got %h want %h", t, c, s_adr, exp_own ? A1 : A0); end
        if (c == 5) begin
          n_cmp++; if (m0_ack !== ~exp_own || m1_ack !== exp_own) begin n_bad++; $display("FAIL alt_ack t%0d: got m0=%b m1=%b want owner %0d", t, m0_ack, m1_ack, exp_own); end
        end
        step();
      end
      exp_own = ~exp_own;
    end
    s_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  task automatic test_overlap();
    do_reset();
    m0_stb = 1'b1; m0_we = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (m0_ack !== 1'b1 || s_adr !== A0) begin n_bad++; $display("FAIL ov_ack0: got ack=%b adr=%h want 1/%h", m0_ack, s_adr, A0); end
    step();
    s_ack = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      n_cmp++; if (s_stb !== 1'b1 || s_adr !== A1 || s_we !== 1'b0) begin n_bad++; $display("FAIL ov_addr b%0d: got stb=%b adr=%h we=%b want 1/%h/0", b, s_stb, s_adr, s_we, A1); end
      n_cmp++; if (s_sel !== SEL0 || s_di !== D0) begin n_bad++; $display("FAIL ov_data b%0d: got sel=%h di=%h want %h/%h", b, s_sel, s_di, SEL0, D0); end
      step();
    end
    s_ack = 1'b1;
    #1;
    n_cmp++; if (s_sel !== 8'h00 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL ov_rdack: got sel=%h m1=%b m0=%b want 00/1/0", s_sel, m1_ack, m0_ack); end
    step();
    s_ack = 1'b0; m1_stb = 1'b0;
    #1;
    n_cmp++; if (s_sel !== 8'h00) begin n_bad++; $display("FAIL ov_rd_nodata: got sel=%h want 00", s_sel); end
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1;
    #1;
    n_cmp++; if (s_adr !== A0 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL wd_c1: got adr=%h ack=%b want %h/0", s_adr, m0_ack, A0); end
    step();
    m0_stb = 1'b0;
    #1;
    n_cmp++; if (s_stb !== 1'b0 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL wd_c2: got stb=%b ack=%b want 0/0", s_stb, m0_ack); end
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (s_adr !== A1 || s_stb !== 1'b1) begin n_bad++; $display("FAIL wd_switch: got adr=%h stb=%b want %h/1", s_adr, s_stb, A1); end
    n_cmp++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_bad++; $display("FAIL wd_ack: got m1=%b m0=%b want 1/0", m1_ack, m0_ack); end
    step();
    s_ack = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m1_stb = 1'b1; m1_we = 1'b1;
    #1;
    n_cmp++; if (s_adr !== A0 || s_stb !== 1'b0) begin n_bad++; $display("FAIL rmb_c1: got adr=%h stb=%b want %h/0", s_adr, s_stb, A0); end
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (s_adr !== A1 || m1_ack !== 1'b1) begin n_bad++; $display("FAIL rmb_ack: got adr=%h ack=%b want %h/1", s_adr, m1_ack, A1); end
    step();
    s_ack = 1'b0;
    #1;
    n_cmp++; if (s_sel !== SEL1 || s_di !== D1) begin n_bad++; $display("FAIL rmb_beat1: got sel=%h di=%h want %h/%h", s_sel, s_di, SEL1, D1); end
    step();
    sys_rst = 1'b1;
    #1;
    n_cmp++; if (s_sel !== SEL1) begin n_bad++; $display("FAIL rmb_beat2: got sel=%h want %h", s_sel, SEL1); end
    step();
    #1;
    n_cmp++; if (s_sel !== 8'h00 || s_di !== 64'h0) begin n_bad++; $display("FAIL rmb_cut: got sel=%h di=%h want 0", s_sel, s_di); end
    n_cmp++; if (s_adr !== A0 || s_stb !== 1'b0) begin n_bad++; $display("FAIL rmb_grant: got adr=%h stb=%b want %h/0", s_adr, s_stb, A0); end
    sys_rst = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
  endtask

  task automatic test_truncate();
    do_reset();
    m0_stb = 1'b1; m0_we = 1'b1; s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    step();
    s_ack = 1'b1;
    #1;
    n_cmp++; if (s_sel !== SEL0) begin n_bad++; $display("FAIL tr_mid: got sel=%h want %h", s_sel, SEL0); end
    step();
    s_ack = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      n_cmp++; if (s_sel !== ((c <= 4) ? SEL0 : 8'h00)) begin n_bad++; $display("FAIL tr_beat c%0d: got sel=%h want %h", c, s_sel, (c <= 4) ? SEL0 : 8'h00); end
      step();
    end
  endtask

  task automatic test_read_broadcast();
    logic [63:0] pats [2];
    pats[0] = 64'hDEAD_BEEF_0123_4567;
    pats[1] = 64'h5A5A_0F0F_C3C3_9696;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      s_do = pats[p];
      #1;
      n_cmp++; if (m0_do !== pats[p] || m1_do !== pats[p]) begin n_bad++; $display("FAIL rd_bcast p%0d: got m0=%h m1=%h want %h", p, m0_do, m1_do, pats[p]); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_alternate();
    test_overlap();
    test_withdraw();
    test_reset_mid_burst();
    test_truncate();
    test_read_broadcast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
